// File: rtl/logic_pod_capture_arbiter.sv
// logic_pod_capture_arbiter
//
// Shares one capture-memory write port between NUM_PODS compression engines.
// Each pod has its own small FIFO. Nonempty FIFOs are granted round-robin onto
// a valid/ready write stream. The capture is sequenced as arm, run, drain, done.
// Written words are counted, and words dropped at a full FIFO are flagged per pod.
//
// Ports
//   clk          capture clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   arm          start-capture pulse, honoured in IDLE/DONE when stop is low
//   stop         end-capture pulse, honoured in RUN
//   capture_len  number of words to write, sampled on an accepted arm
//   pod_valid    per-pod word strobe (no backpressure toward the pods)
//   pod_data     pod i word at bits [i*WIDTH +: WIDTH]
//   pod_en       compressor enable, high only in RUN
//   mem_wr_en    write valid
//   mem_ready    write ready
//   mem_wr_data  word being written
//   mem_wr_pod   source pod index of the word
//   mem_wr_addr  0-based word index within the capture
//   busy         state is RUN or DRAIN
//   done         state is DONE
//   overflow     sticky per-pod drop flags
module logic_pod_capture_arbiter #(
    parameter int unsigned NUM_PODS = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      arm,
    input  logic                      stop,
    input  logic [31:0]               capture_len,
    input  logic [NUM_PODS-1:0]       pod_valid,
    input  logic [NUM_PODS*WIDTH-1:0] pod_data,
    output logic                      pod_en,
    output logic                      mem_wr_en,
    input  logic                      mem_ready,
    output logic [WIDTH-1:0]          mem_wr_data,
    output logic [2:0]                mem_wr_pod,
    output logic [31:0]               mem_wr_addr,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_PODS-1:0]       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = (NUM_PODS > 1) ? $clog2(NUM_PODS) : 1;
    localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);
    localparam logic [PW-1:0] LastPod = PW'(NUM_PODS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q;
    logic                  wr_en_q;
    logic [WIDTH-1:0]      data_q;
    logic [2:0]            pod_q;
    logic [31:0]           addr_q;
    logic [31:0]           count_q;
    logic [31:0]           len_q;
    logic [PW-1:0]         last_q;
    logic [NUM_PODS-1:0]   overflow_q;

    logic [WIDTH-1:0]      fifo_mem_q [NUM_PODS][DEPTH];
    logic [AW:0]           wr_ptr_q   [NUM_PODS];
    logic [AW:0]           rd_ptr_q   [NUM_PODS];

    logic [NUM_PODS-1:0]   fifo_empty;
    logic [NUM_PODS-1:0]   fifo_full;
    logic                  active;
    logic                  hs;
    logic                  last_hs;
    logic                  loadable;
    logic                  start;
    logic                  gnt_any;
    logic                  gnt;
    logic [PW-1:0]         gnt_idx;
    logic                  drain_done;

    always_comb begin
        for (int i = 0; i < NUM_PODS; i++) begin
            fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            fifo_full[i]  = ((wr_ptr_q[i] - rd_ptr_q[i]) == FullLvl);
        end
    end

    assign active   = (state_q == StRun) || (state_q == StDrain);
    assign hs       = wr_en_q && mem_ready;
    // The handshake that completes the capture length ends it immediately.
    assign last_hs  = hs && ((count_q + 32'd1) == len_q);
    assign loadable = !wr_en_q || mem_ready;
    assign start    = arm && !stop && ((state_q == StIdle) || (state_q == StDone));

    // Round-robin search starting just after the last granted pod.
    always_comb begin
        int unsigned idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int unsigned k = 1; k <= NUM_PODS; k++) begin
            idx = (int'(last_q) + k) % NUM_PODS;
            if (!gnt_any && !fifo_empty[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
            end
        end
    end

    assign gnt = active && loadable && !last_hs && gnt_any;

    // Drain finishes once every FIFO is empty and the output register is empty
    // or being accepted this cycle.
    assign drain_done = (state_q == StDrain) && (&fifo_empty) && loadable && !last_hs;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_en_q    <= 1'b0;
            data_q     <= '0;
            pod_q      <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            len_q      <= '0;
            last_q     <= LastPod;
            overflow_q <= '0;
            for (int i = 0; i < NUM_PODS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        count_q    <= '0;
                        overflow_q <= '0;
                        last_q     <= LastPod;
                        wr_en_q    <= 1'b0;
                        len_q      <= capture_len;
                        for (int i = 0; i < NUM_PODS; i++) begin
                            wr_ptr_q[i] <= '0;
                            rd_ptr_q[i] <= '0;
                        end
                        state_q <= (capture_len == 32'd0) ? StDone : StRun;
                    end
                end
                StRun, StDrain: begin
                    if (hs) begin
                        count_q <= count_q + 32'd1;
                    end
                    if (last_hs) begin
                        state_q <= StDone;
                        wr_en_q <= 1'b0;
                        for (int i = 0; i < NUM_PODS; i++) begin
                            wr_ptr_q[i] <= '0;
                            rd_ptr_q[i] <= '0;
                        end
                    end else begin
                        if (state_q == StRun) begin
                            for (int i = 0; i < NUM_PODS; i++) begin
                                if (pod_valid[i]) begin
                                    // Fullness is judged before any same-cycle pop.
                                    if (fifo_full[i]) begin
                                        overflow_q[i] <= 1'b1;
                                    end else begin
                                        fifo_mem_q[i][wr_ptr_q[i][AW-1:0]] <=
                                            pod_data[i*WIDTH +: WIDTH];
                                        wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                                    end
                                end
                            end
                        end
                        if (gnt) begin
                            rd_ptr_q[gnt_idx] <= rd_ptr_q[gnt_idx] + 1'b1;
                            data_q  <= fifo_mem_q[gnt_idx][rd_ptr_q[gnt_idx][AW-1:0]];
                            pod_q   <= 3'(gnt_idx);
                            addr_q  <= count_q + {31'd0, hs};
                            wr_en_q <= 1'b1;
                            last_q  <= gnt_idx;
                        end else if (hs) begin
                            wr_en_q <= 1'b0;
                        end
                        if ((state_q == StRun) && stop) begin
                            state_q <= StDrain;
                        end else if (drain_done) begin
                            state_q <= StDone;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pod_en      = (state_q == StRun);
    assign busy        = active;
    assign done        = (state_q == StDone);
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_data = data_q;
    assign mem_wr_pod  = pod_q;
    assign mem_wr_addr = addr_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_logic_pod_capture_arbiter.sv
// Directed bench for logic_pod_capture_arbiter with a write scoreboard.
module tb_logic_pod_capture_arbiter;

    localparam int NP = 4;
    localparam int W  = 32;

    logic            clk;
    logic            rst_n;
    logic            arm;
    logic            stop;
    logic [31:0]     capture_len;
    logic [NP-1:0]   pod_valid;
    logic [NP*W-1:0] pod_data;
    logic            pod_en;
    logic            mem_wr_en;
    logic            mem_ready;
    logic [W-1:0]    mem_wr_data;
    logic [2:0]      mem_wr_pod;
    logic [31:0]     mem_wr_addr;
    logic            busy;
    logic            done;
    logic [NP-1:0]   overflow;

    logic_pod_capture_arbiter #(
        .NUM_PODS(NP),
        .WIDTH   (W),
        .DEPTH   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arm        (arm),
        .stop       (stop),
        .capture_len(capture_len),
        .pod_valid  (pod_valid),
        .pod_data   (pod_data),
        .pod_en     (pod_en),
        .mem_wr_en  (mem_wr_en),
        .mem_ready  (mem_ready),
        .mem_wr_data(mem_wr_data),
        .mem_wr_pod (mem_wr_pod),
        .mem_wr_addr(mem_wr_addr),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  pod;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   writes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int pod, input int data, input int addr);
        exp_t e;
        e.pod  = 3'(pod);
        e.data = 32'(data);
        e.addr = 32'(addr);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int len);
        arm         = 1'b1;
        capture_len = 32'(len);
        tick();
        arm = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic wait_sb(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pod_en"}, pod_en, 0);
        check({tag, "_wr_en"}, mem_wr_en, 0);
        check({tag, "_data"}, mem_wr_data, 0);
        check({tag, "_pod"}, mem_wr_pod, 0);
        check({tag, "_addr"}, mem_wr_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    // Write monitor: scores every handshake and checks the stream holds while stalled.
    initial begin
        logic        stall_prev;
        logic [31:0] held_data;
        logic [31:0] held_addr;
        logic [2:0]  held_pod;
        exp_t        e;
        stall_prev = 1'b0;
        held_data  = '0;
        held_addr  = '0;
        held_pod   = '0;
        forever begin
            @(negedge clk);
            if (stall_prev) begin
                check("stall_hold_en", mem_wr_en, 1);
                check("stall_hold_data", mem_wr_data, held_data);
                check("stall_hold_pod", mem_wr_pod, held_pod);
                check("stall_hold_addr", mem_wr_addr, held_addr);
            end
            if (rst_n === 1'b1 && mem_wr_en === 1'b1 && mem_ready === 1'b1) begin
                writes++;
                check("write_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_pod", mem_wr_pod, e.pod);
                    check("wr_data", mem_wr_data, e.data);
                    check("wr_addr", mem_wr_addr, e.addr);
                end
            end
            stall_prev = (rst_n === 1'b1) && (mem_wr_en === 1'b1) && (mem_ready === 1'b0);
            held_data  = mem_wr_data;
            held_addr  = mem_wr_addr;
            held_pod   = mem_wr_pod;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst_n       = 1'b0;
        arm         = 1'b0;
        stop        = 1'b0;
        capture_len = '0;
        pod_valid   = '0;
        pod_data    = '0;
        mem_ready   = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();

        // arm together with stop in IDLE is ignored
        arm         = 1'b1;
        stop        = 1'b1;
        capture_len = 32'd100;
        tick();
        arm  = 1'b0;
        stop = 1'b0;
        check("armstop_busy", busy, 0);
        check("armstop_done", done, 0);
        check("armstop_pod_en", pod_en, 0);

        // one word from each pod in the same cycle
        mem_ready = 1'b1;
        do_arm(100);
        check("t1_pod_en", pod_en, 1);
        check("t1_busy", busy, 1);
        for (int i = 0; i < NP; i++) begin
            pod_data[i*W +: W] = 32'h10 + 32'(i);
            push_exp(i, 32'h10 + i, i);
        end
        pod_valid = 4'hf;
        tick();
        pod_valid = '0;
        check("t1_lat_edge1", mem_wr_en, 0);
        tick();
        check("t1_lat_edge2", mem_wr_en, 1);
        wait_sb("t1_drained", 20);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t1_pod_en_off", pod_en, 0);
        wait_done("t1_done", 20);
        check("t1_overflow", overflow, 0);

        // pod 1 floods its FIFO while the memory is stalled
        mem_ready = 1'b0;
        do_arm(100);
        w0 = writes;
        for (int j = 0; j < 20; j++) begin
            pod_valid = 4'b0010;
            pod_data  = '0;
            pod_data[1*W +: W] = 32'h100 + 32'(j);
            if (j < 9) push_exp(1, 32'h100 + j, j);
            tick();
        end
        pod_valid = '0;
        check("t2_overflow", overflow, 4'b0010);
        mem_ready = 1'b1;
        wait_sb("t2_drained", 30);
        repeat (3) tick();
        check("t2_writes", writes - w0, 9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t2_done", 20);

        // capture length reached while every pod keeps streaming
        mem_ready = 1'b1;
        do_arm(5);
        w0 = writes;
        push_exp(0, 32'h000, 0);
        push_exp(1, 32'h100, 1);
        push_exp(2, 32'h200, 2);
        push_exp(3, 32'h300, 3);
        push_exp(0, 32'h001, 4);
        begin
            int j = 0;
            while (!done && j < 40) begin
                pod_valid = 4'hf;
                for (int i = 0; i < NP; i++) pod_data[i*W +: W] = 32'h100 * 32'(i) + 32'(j);
                tick();
                j++;
            end
        end
        pod_valid = '0;
        check("t3_done", done, 1);
        check("t3_pod_en", pod_en, 0);
        check("t3_wr_en", mem_wr_en, 0);
        repeat (4) tick();
        check("t3_writes", writes - w0, 5);
        check("t3_sb", sb.size(), 0);

        // three words per pod, stop, then drain with mem_ready toggling
        mem_ready = 1'b1;
        do_arm(100);
        w0 = writes;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NP; i++) push_exp(i, 32'h100 * i + r, 4 * r + i);
        for (int j = 0; j < 3; j++) begin
            pod_valid = 4'hf;
            for (int i = 0; i < NP; i++) pod_data[i*W +: W] = 32'h100 * 32'(i) + 32'(j);
            tick();
            mem_ready = !mem_ready;
        end
        pod_valid = '0;
        stop      = 1'b1;
        tick();
        mem_ready = !mem_ready;
        stop      = 1'b0;
        check("t4_draining", busy, 1);
        begin
            int n = 0;
            while (!done && n < 60) begin
                tick();
                mem_ready = !mem_ready;
                n++;
            end
        end
        check("t4_done", done, 1);
        check("t4_writes", writes - w0, 12);
        check("t4_sb", sb.size(), 0);

        // zero-length capture finishes immediately
        mem_ready = 1'b1;
        w0 = writes;
        do_arm(0);
        check("t5_done", done, 1);
        check("t5_busy", busy, 0);
        repeat (5) tick();
        check("t5_writes", writes - w0, 0);

        // reset in the middle of a capture with words pending
        mem_ready = 1'b0;
        do_arm(100);
        pod_valid = 4'hf;
        for (int i = 0; i < NP; i++) pod_data[i*W +: W] = 32'hA0 + 32'(i);
        tick();
        tick();
        pod_valid = '0;
        tick();
        check("t6_pending", mem_wr_en, 1);
        rst_n = 1'b0;
        tick();
        check_reset("t6_reset");
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        w0 = writes;
        repeat (10) tick();
        check("t6_writes", writes - w0, 0);
        check("t6_wr_en", mem_wr_en, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("final_sb", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_pod_capture_arbiter.md
# logic_pod_capture_arbiter

Shares one capture-memory write port between NUM_PODS logic-pod compression engines, each emitting compressed 32-bit words on a valid strobe. It buffers each pod in a small FIFO, grants nonempty FIFOs round-robin onto a valid/ready memory write stream, and sequences the capture: arm, run, drain, done. It also counts written words and flags per-pod overflow. It sits between the compression blocks and the capture RAM/DRAM writer.

## Interface
- NUM_PODS, 4, number of compression sources (2..8)
- WIDTH, 32, compressed word width
- DEPTH, 8, per-pod FIFO depth (power of 2)
- clk  in  1  capture clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- arm  in  1  start-capture pulse
- stop  in  1  end-capture pulse
- capture_len  in  32  words to write; sampled on accepted arm
- pod_valid  in  NUM_PODS  per-pod word strobe; no backpressure toward pods
- pod_data  in  NUM_PODS*WIDTH  pod i at bits [i*WIDTH +: WIDTH]
- pod_en  out  1  enable to compressors; high only in RUN
- mem_wr_en  out  1  output valid
- mem_ready  in  1  output ready
- mem_wr_data  out  WIDTH  word
- mem_wr_pod  out  3  source pod index
- mem_wr_addr  out  32  word index within capture (0-based)
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- overflow  out  NUM_PODS  sticky per-pod drop flags

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: arm, with stop low and capture_len != 0 -> RUN. Clears the count, FIFOs, overflow and the round-robin pointer (last = NUM_PODS-1).
- IDLE: arm with capture_len == 0 -> DONE, no writes.
- IDLE: arm together with stop -> stays IDLE.
- RUN: each cycle, pod i with pod_valid pushes pod_data[i] into FIFO i if not full.
  - If FIFO i is full, the word is dropped and overflow[i] is set.
  - Multiple pods may push in the same cycle.
- RUN: stop -> DRAIN. Pod input in the stop cycle is still accepted.
- DRAIN: no pushes. Pops continue until all FIFOs and the output register are empty -> DONE.
- RUN/DRAIN: the handshake that makes the count equal capture_len -> DONE immediately. Remaining FIFO contents are discarded and FIFOs cleared.
- DONE: holds. arm -> same action as in IDLE (restart). stop is ignored.
- Arm is ignored in RUN and DRAIN. Stop is ignored in IDLE and DONE.
- Arbiter:
  - The output register is loadable when mem_wr_en is low, or mem_wr_en && mem_ready.
  - When loadable, grant the first nonempty FIFO searching last+1, last+2, ... modulo NUM_PODS.
  - Pop it and load mem_wr_data/mem_wr_pod. Set last to the granted index.
  - With no grant, mem_wr_en drops after the handshake.
- mem_wr_en stays high with data/pod/addr stable until mem_ready.
- Count increments on each handshake. mem_wr_addr equals the count at the time the word is presented. Width 32, no wrap (capture_len bounds it).
- No grants in IDLE or DONE. Entering DONE clears mem_wr_en.

## Timing
- Reset values: state IDLE, pod_en 0, mem_wr_en 0, mem_wr_data 0, mem_wr_pod 0, mem_wr_addr 0, busy 0, done 0, overflow 0, FIFOs empty, last = NUM_PODS-1.
- pod_en rises the cycle after an accepted arm and falls the cycle after stop.
- Latency from a pod word sampled at edge N, with an idle output: FIFO holds it after N; grant at edge N+1; mem_wr_en high after N+1 (two edges).
- Throughput is one word per cycle when mem_ready is held high.
- FIFO full test uses occupancy before the same-cycle pop. A push to a full FIFO being popped the same cycle is still dropped.
- done rises the cycle after the final handshake, or after the last drain pop is accepted.
- Reset mid-capture aborts the capture: all state returns to reset values next edge, no further writes.

## Test plan
- Pods 0–3 each pulse valid once in the same cycle with data 0x10..0x13, capture_len=100, mem_ready=1 -> four writes on consecutive cycles, pods 0,1,2,3, addr 0..3; first mem_wr_en two edges after the valids.
- Pod 1 valid every cycle for 20 cycles, mem_ready=0 -> overflow=4'b0010. After mem_ready=1, exactly DEPTH+1 words written: 8 from the FIFO plus 1 held in the output register.
- capture_len=5, all pods valid continuously -> exactly 5 handshakes, addr 0..4, done the next cycle, pod_en low, FIFOs cleared.
- stop after 3 pushes per pod, mem_ready toggling 1/0 -> DRAIN writes all 12 words round-robin with no pod data changes while stalled, then DONE.
- arm with capture_len=0 -> done after one edge, zero writes. arm+stop in IDLE -> remains IDLE.
- rst_n low for one cycle mid-RUN with words pending -> next cycle all outputs at reset values, no writes after.
